mem_seq: RTL and testbench
==========================

# mem_seq

Parametrised byte-serial load/store sequencer between the MEM pipeline stage and the 8-bit memory/HCI port. It accepts one load or store request (byte, half, word) with a level request/done handshake and serialises it into per-byte bus cycles. Loads are pipelined against a configurable memory read latency, with correct sign/zero extension. While a request is in flight it drives the pipeline stall.

## Interface
- `ADDR_W`, 32, memory address width; byte addresses wrap modulo 2^ADDR_W.
- `READ_LAT`, 2, cycles from address presented to read byte valid on `mem_din_i` (≥1).
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_i`  in  1  access request level; held until `done_o`.
- `we_i`  in  1  1 = store, 0 = load.
- `sel_i`  in  2  size: 00 byte, 01 half, 10 word, 11 reserved.
- `sign_i`  in  1  load sign-extend enable.
- `addr_i`  in  ADDR_W  byte address of the access.
- `wdata_i`  in  32  store data, low bytes first.
- `rdata_o`  out  32  extended load result; held until next load completes.
- `done_o`  out  1  one-cycle completion pulse.
- `stall_o`  out  1  `req_i & ~done_o`, combinational.
- `busy_o`  out  1  FSM not in IDLE.
- `mem_addr_o`  out  ADDR_W  byte address to memory.
- `mem_wr_o`  out  1  memory write strobe.
- `mem_dout_o`  out  8  write byte.
- `mem_din_i`  in  8  read byte.
- `fault_o`  out  1  misaligned-access pulse (only with `MEM_MISALIGN_TRAP_EN`).

## Operation
- N = 1/2/4 bytes for byte/half/word. Byte k goes to `addr_i + k` (mod 2^ADDR_W), `wdata_i[8k+7:8k]`.
- FSM: IDLE -> ISSUE (N cycles, one address per cycle) -> DRAIN (loads only, READ_LAT cycles) -> DONE (1 cycle, `done_o`=1) -> IDLE.
- IDLE accepts when `req_i`=1. Request fields are latched at acceptance; later changes are ignored.
- Store: `mem_wr_o`=1 with address and byte for each ISSUE cycle.
- Load: `mem_wr_o`=0. The byte for the address presented in cycle c is captured from `mem_din_i` at the end of cycle c+READ_LAT into byte lane k.
- Extension: byte uses bit 7 and half uses bit 15 when `sign_i`=1, otherwise zero-fill. Word is unmodified. `rdata_o` updates in the DONE cycle.
- Reserved `sel_i`=11 goes directly to DONE with no bus traffic. `rdata_o` becomes 0 for loads.
- Outside ISSUE, `mem_addr_o`=0, `mem_wr_o`=0 and `mem_dout_o`=0. The HCI requires a zero address when idle.
- The requester drops `req_i` or presents a new request in the cycle after `done_o`. A new request is only accepted from IDLE, one cycle after DONE.

## Timing
- Reset values: all outputs 0, FSM IDLE, latched byte lanes 0.
- `rst` low mid-access clears state immediately. `mem_wr_o` falls without waiting for the clock, and the partial access is discarded. After reset the request restarts from byte 0.
- Request seen in cycle 0: byte 0 is on the bus in cycle 1, byte N-1 in cycle N.
- Store: `done_o` in cycle N+1.
- Load: `done_o` in cycle N+READ_LAT+1.
- Reserved size: `done_o` in cycle 1.
- `stall_o` is high from cycle 0 through the cycle before `done_o`.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A half access with `addr_i[0]`=1, or a word access with `addr_i[1:0]`≠0, performs no bus cycles.
  - `done_o` and `fault_o` pulse together in cycle 1; `rdata_o` is unchanged.
- Undefined: `fault_o` is tied 0 and misaligned accesses are sequenced byte-wise like aligned ones.

## Test plan
- Word load, addr 0x100, memory bytes 11,22,33,84, READ_LAT=2 -> addresses 0x100..0x103 in cycles 1-4; `done_o` cycle 7; `rdata_o`=0x84332211.
- Byte load of 0x80: `sign_i`=1 -> 0xFFFFFF80; `sign_i`=0 -> 0x00000080. Half load 0x8001 signed -> 0xFFFF8001.
- Half store 0x0000ABCD at 0x2000 -> 0xCD@0x2000 cycle 1, 0xAB@0x2001 cycle 2 with `mem_wr_o`=1; `done_o` cycle 3; bus zero cycle 3.
- Word store with `rst` low after byte 1 -> `mem_wr_o`=0 immediately, all outputs 0. Re-request restarts at byte 0 with the base address.
- Word load at 0x1002: with macro -> `fault_o`=`done_o`=1 in cycle 1, no bus cycles. Without -> bytes from 0x1002..0x1005.
- Half store at address 0xFFFFFFFF -> bytes to 0xFFFFFFFF then 0x00000000. Back-to-back requests are accepted one cycle after each `done_o`.

Source files
------------

// File: rtl/mem_seq.sv
// mem_seq: byte-serial load/store sequencer between the MEM stage and the
// 8-bit memory/HCI port. One request (byte/half/word) is split into one bus
// cycle per byte; loads wait READ_LAT cycles for the last byte and are then
// sign/zero extended.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no bus cycles, fault_o pulses with done_o).
module mem_seq #(
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        sel_i,
  input  logic              sign_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              done_o,
  output logic              stall_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_o,
  output logic [7:0]        mem_dout_o,
  input  logic [7:0]        mem_din_i,
  output logic              fault_o
);

  localparam int DW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, sign_q;
  logic [1:0]        sel_q, k_q, last_k;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0][7:0]   wdata_q, lanes_q, lanes_d;
  logic [DW-1:0]     drain_q;
  logic [31:0]       rdata_q;
  logic              misalign;
  // Read-return tracking: one stage per cycle of memory latency.
  logic [READ_LAT-1:0] pv_q;
  logic [1:0]          pk_q [READ_LAT];

`ifdef MEM_MISALIGN_TRAP_EN
  logic fault_q;
  assign misalign = (sel_i == 2'b01 && addr_i[0]) ||
                    (sel_i == 2'b10 && addr_i[1:0] != 2'b00);
  assign fault_o  = done_o & fault_q;

  // Remember whether the accepted request was trapped as misaligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_q <= 1'b0;
    else if (state_q == S_IDLE && req_i) fault_q <= misalign;
  end
`else
  assign misalign = 1'b0;
  assign fault_o  = 1'b0;
`endif

  // Sign/zero extension of the assembled load lanes.
  function automatic logic [31:0] extend(logic [3:0][7:0] l, logic [1:0] sel,
                                         logic sgn);
    case (sel)
      2'b00:   extend = {{24{sgn & l[0][7]}}, l[0]};
      2'b01:   extend = {{16{sgn & l[1][7]}}, l[1], l[0]};
      default: extend = l;
    endcase
  endfunction

  assign last_k  = (sel_q == 2'b00) ? 2'd0 : (sel_q == 2'b01) ? 2'd1 : 2'd3;
  assign rdata_o = rdata_q;
  assign stall_o = req_i & ~done_o;

  // Byte returned this cycle merged into the lanes it belongs to.
  always_comb begin
    lanes_d = lanes_q;
    if (pv_q[READ_LAT-1]) lanes_d[pk_q[READ_LAT-1]] = mem_din_i;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and bus outputs; bus is forced to zero outside ISSUE.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d    = state_q;
    mem_addr_o = '0;
    mem_wr_o   = 1'b0;
    mem_dout_o = 8'h00;
    busy_o     = (state_q != S_IDLE);
    done_o     = (state_q == S_DONE);
    case (state_q)
      S_IDLE:  if (req_i) state_d = (sel_i == 2'b11 || misalign) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        mem_addr_o = addr_q + ADDR_W'(k_q);
        mem_wr_o   = we_q;
        mem_dout_o = we_q ? wdata_q[k_q] : 8'h00;
        if (k_q == last_k) state_d = we_q ? S_DONE : S_DRAIN;
      end
      S_DRAIN: if (drain_q == DW'(READ_LAT - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latching, byte counters, read-return pipeline and load result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      sel_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      k_q     <= 2'd0;
      drain_q <= '0;
      lanes_q <= '0;
      rdata_q <= 32'h0;
      pv_q    <= '0;
      // NOTE: the tracking array is tiny and must be clean after an aborted
      // access, so it is reset like ordinary flops rather than left as RAM.
      for (int i = 0; i < READ_LAT; i++) pk_q[i] <= 2'd0;
    end else begin
      // NOTE: non-blocking throughout so the shift stages read old values.
      pv_q[0] <= (state_q == S_ISSUE) && !we_q;
      pk_q[0] <= k_q;
      for (int i = 1; i < READ_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pk_q[i] <= pk_q[i-1];
      end
      lanes_q <= lanes_d;
      case (state_q)
        S_IDLE: if (req_i) begin
          we_q    <= we_i;
          sign_q  <= sign_i;
          sel_q   <= sel_i;
          addr_q  <= addr_i;
          wdata_q <= wdata_i;
          k_q     <= 2'd0;
          drain_q <= '0;
          lanes_q <= '0;
          if (sel_i == 2'b11 && !we_i) rdata_q <= 32'h0;
        end
        S_ISSUE: k_q <= k_q + 2'd1;
        S_DRAIN: begin
          drain_q <= drain_q + DW'(1);
          if (state_d == S_DONE) rdata_q <= extend(lanes_d, sel_q, sign_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_seq.sv
// Self-checking bench for mem_seq: a transaction-level model builds the
// expected per-cycle bus trace and load result, a compare process checks the
// DUT every cycle, and literal values pin the model on the key cases.
module tb_mem_seq;
  localparam int RL = 2;

  logic        clk, rst, req_i, we_i, sign_i;
  logic [1:0]  sel_i;
  logic [31:0] addr_i, wdata_i, rdata_o, mem_addr_o;
  logic        done_o, stall_o, busy_o, mem_wr_o, fault_o;
  logic [7:0]  mem_dout_o, mem_din_i;

  int n_tests = 0;
  int n_fail  = 0;

  mem_seq #(.ADDR_W(32), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .sel_i(sel_i),
    .sign_i(sign_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .done_o(done_o), .stall_o(stall_o), .busy_o(busy_o),
    .mem_addr_o(mem_addr_o), .mem_wr_o(mem_wr_o), .mem_dout_o(mem_dout_o),
    .mem_din_i(mem_din_i), .fault_o(fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Memory contents: a few fixed bytes, everything else derived from address.
  logic [7:0] mem_bytes [logic [31:0]];
  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem_bytes.exists(a)) return mem_bytes[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Memory responder: the byte for the address seen in cycle c is driven
  // during cycle c+RL.
  logic [31:0] hist [RL+1];
  always @(negedge clk) begin
    for (int i = RL; i > 0; i--) hist[i] = hist[i-1];
    hist[0]   = mem_addr_o;
    mem_din_i = mem_rd(hist[RL]);
  end

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  dout;
    logic        chk_dout;
    logic        done, busy, stall, fault;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];
  logic [31:0] exp_rdata = 32'h0;

  // Single compare process: one expected entry per cycle, checked mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("addr",  mem_addr_o, e.addr);
      check("wr",    32'(mem_wr_o), 32'(e.wr));
      if (e.chk_dout) check("dout", 32'(mem_dout_o), 32'(e.dout));
      check("done",  32'(done_o),  32'(e.done));
      check("busy",  32'(busy_o),  32'(e.busy));
      check("stall", 32'(stall_o), 32'(e.stall));
      check("fault", 32'(fault_o), 32'(e.fault));
      check("rdata", rdata_o, e.rdata);
    end
  end

  function automatic bit model_trap(input logic [1:0] sel, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (sel == 2'b01 && (a % 2) != 0) || (sel == 2'b10 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sel, input logic sgn,
                                             input logic [31:0] base);
    logic [31:0] v = 32'h0;
    int n;
    if (sel == 2'b11) return 32'h0;
    n = (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : 4;
    for (int k = 0; k < n; k++) v = v + (32'(mem_rd(base + 32'(k))) << (8 * k));
    if (sgn && sel == 2'b00 && v >= 32'h80)   v = v + 32'hFFFF_FF00;
    if (sgn && sel == 2'b01 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  // Present one request at the start of cycle 0; returns at the start of
  // the cycle after done_o with req_i still high.
  task automatic run_txn(input logic we, input logic [1:0] sel, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    bit tr = model_trap(sel, a);
    bit bypass = tr || (sel == 2'b11);
    int n = (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : 4;
    int d = bypass ? 1 : (we ? n + 1 : n + RL + 1);
    logic [31:0] new_rd = (!we && !tr) ? model_load(sel, sgn, a) : exp_rdata;
    req_i = 1'b1; we_i = we; sel_i = sel; sign_i = sgn; addr_i = a; wdata_i = wd;
    for (int c = 0; c <= d; c++) begin
      e.addr = 32'h0; e.wr = 1'b0; e.dout = 8'h00; e.chk_dout = 1'b1;
      e.done = (c == d); e.busy = (c > 0); e.stall = (c < d);
      e.fault = (c == d) && tr;
      e.rdata = (c == d) ? new_rd : exp_rdata;
      if (!bypass && c >= 1 && c <= n) begin
        e.addr = a + 32'(c - 1);
        e.wr = we;
        e.dout = we ? wd[8*(c-1) +: 8] : 8'h00;
        e.chk_dout = we;
      end
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    // Request fields must have been latched; disturb them.
    addr_i = ~a; wdata_i = ~wd; sign_i = ~sgn; sel_i = ~sel;
    repeat (d) @(negedge clk);
    @(posedge clk); #1;
    exp_rdata = new_rd;
  endtask

  task automatic idle(input int n);
    exp_t e;
    req_i = 1'b0;
    for (int c = 0; c < n; c++) begin
      e.addr = 32'h0; e.wr = 1'b0; e.dout = 8'h00; e.chk_dout = 1'b1;
      e.done = 1'b0; e.busy = 1'b0; e.stall = 1'b0; e.fault = 1'b0;
      e.rdata = exp_rdata;
      exp_q.push_back(e);
    end
    repeat (n) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i <= RL; i++) hist[i] = 32'h0;
    mem_din_i = 8'h00;
    rst = 1'b0; req_i = 1'b0; we_i = 1'b0; sel_i = 2'b00; sign_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0;
    mem_bytes[32'h100] = 8'h11; mem_bytes[32'h101] = 8'h22;
    mem_bytes[32'h102] = 8'h33; mem_bytes[32'h103] = 8'h84;
    mem_bytes[32'h200] = 8'h80;
    mem_bytes[32'h300] = 8'h01; mem_bytes[32'h301] = 8'h80;

    #3;
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_done",  32'(done_o), 32'h0);
    check("rst_busy",  32'(busy_o), 32'h0);
    check("rst_addr",  mem_addr_o, 32'h0);
    check("rst_wr",    32'(mem_wr_o), 32'h0);
    check("rst_fault", 32'(fault_o), 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    run_txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    check("word_load_lit", rdata_o, 32'h8433_2211);
    idle(1);
    run_txn(1'b0, 2'b00, 1'b1, 32'h200, 32'h0);
    check("byte_s_lit", rdata_o, 32'hFFFF_FF80);
    run_txn(1'b0, 2'b00, 1'b0, 32'h200, 32'h0);
    check("byte_u_lit", rdata_o, 32'h0000_0080);
    run_txn(1'b0, 2'b01, 1'b1, 32'h300, 32'h0);
    check("half_s_lit", rdata_o, 32'hFFFF_8001);
    idle(1);
    run_txn(1'b1, 2'b01, 1'b0, 32'h2000, 32'h0000_ABCD);
    idle(1);
    run_txn(1'b0, 2'b10, 1'b0, 32'h1002, 32'h0);
    idle(1);
    run_txn(1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234);
    run_txn(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D);
    run_txn(1'b0, 2'b11, 1'b1, 32'h500, 32'h0);
    check("rsvd_load_lit", rdata_o, 32'h0);
    run_txn(1'b1, 2'b11, 1'b0, 32'h504, 32'h1111_2222);
    idle(2);
    run_txn(1'b0, 2'b01, 1'b1, 32'h300, 32'h0);

    // Abort a word store by reset while byte 2 is on the bus.
    req_i = 1'b1; we_i = 1'b1; sel_i = 2'b10; sign_i = 1'b0;
    addr_i = 32'h3000; wdata_i = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      e.addr = (c == 0) ? 32'h0 : 32'h3000 + 32'(c - 1);
      e.wr = (c > 0); e.dout = (c == 0) ? 8'h00 : (c == 1) ? 8'hEF : 8'hBE;
      e.chk_dout = 1'b1; e.done = 1'b0; e.busy = (c > 0); e.stall = 1'b1;
      e.fault = 1'b0; e.rdata = exp_rdata;
      exp_q.push_back(e);
    end
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_wr", 32'(mem_wr_o), 32'h1);
    rst = 1'b0; req_i = 1'b0;
    #1;
    check("arst_wr",    32'(mem_wr_o), 32'h0);
    check("arst_addr",  mem_addr_o, 32'h0);
    check("arst_dout",  32'(mem_dout_o), 32'h0);
    check("arst_busy",  32'(busy_o), 32'h0);
    check("arst_done",  32'(done_o), 32'h0);
    check("arst_stall", 32'(stall_o), 32'h0);
    check("arst_rdata", rdata_o, 32'h0);
    exp_rdata = 32'h0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b1, 2'b10, 1'b0, 32'h3000, 32'hDEAD_BEEF);
    run_txn(1'b0, 2'b01, 1'b0, 32'h300, 32'h0);
    check("half_u_lit", rdata_o, 32'h0000_8001);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
